// File: rtl/matmul_out_streamer_pkg.sv
// Shared definitions for the MatMul result streamer and its companion packer:
// FSM state encodings plus index-width and beat-count helpers.
package matmul_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Index widths never collapse to zero bits, even for a dimension of size 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_count(input int heads, input int rows, input int cols,
                                    input int lanes);
    return (heads * rows * cols) / lanes;
  endfunction

endpackage

// File: rtl/matmul_out_streamer_if.sv
// Narrow valid/ready beat stream carrying one LANES-wide slice of a result row
// together with its head/row/column position and end-of-row/end-of-transfer flags.
interface matmul_out_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int HEAD_W     = 4,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 7
);
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH*LANES-1:0] out_data;
  logic [HEAD_W-1:0]           out_head;
  logic [ROW_W-1:0]            out_row;
  logic [COL_W-1:0]            out_col;
  logic                        out_last_row;
  logic                        out_last;

  modport master (
    output out_valid, out_data, out_head, out_row, out_col, out_last_row, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_head, out_row, out_col, out_last_row, out_last,
    output out_ready
  );
endinterface

// File: rtl/matmul_out_streamer_beat_counter.sv
// Nested head/row/col beat position counter; exposes the position it will hold
// after this cycle so a caller can register data for that beat in lock-step.
module matmul_beat_counter
  import matmul_pkg::*;
#(
  parameter int MATMUL_NUM     = 12,
  parameter int OUTPUT_SHAPE_1 = 128,
  parameter int OUTPUT_SHAPE_2 = 128,
  parameter int LANES          = 16,
  parameter int HEAD_W         = idx_w(MATMUL_NUM),
  parameter int ROW_W          = idx_w(OUTPUT_SHAPE_1),
  parameter int COL_W          = idx_w(OUTPUT_SHAPE_2)
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  output logic [HEAD_W-1:0] nxt_head,
  output logic [ROW_W-1:0]  nxt_row,
  output logic [COL_W-1:0]  nxt_col,
  output logic              nxt_last_row,
  output logic              nxt_last
);

  logic [HEAD_W-1:0] head_q, head_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [COL_W-1:0]  col_q,  col_d;

  // Column steps by LANES, wrapping into row, wrapping into head.
  always_comb begin
    head_d = head_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clear) begin
      head_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (en) begin
      if (col_q == COL_W'(OUTPUT_SHAPE_2 - LANES)) begin
        col_d = '0;
        if (row_q == ROW_W'(OUTPUT_SHAPE_1 - 1)) begin
          row_d  = '0;
          head_d = (head_q == HEAD_W'(MATMUL_NUM - 1)) ? '0 : head_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + COL_W'(LANES);
      end
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      head_q <= head_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign nxt_head     = head_d;
  assign nxt_row      = row_d;
  assign nxt_col      = col_d;
  assign nxt_last_row = (col_d == COL_W'(OUTPUT_SHAPE_2 - LANES));
  assign nxt_last     = nxt_last_row && (row_d == ROW_W'(OUTPUT_SHAPE_1 - 1)) &&
                        (head_d == HEAD_W'(MATMUL_NUM - 1));

endmodule

// File: rtl/matmul_out_streamer.sv
// Drains the flat MatMul result bus onto a LANES-wide valid/ready stream,
// head-major then row-major, one beat per cycle when the consumer keeps up.
module matmul_out_streamer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MATMUL_NUM     = 12,
  parameter int OUTPUT_SHAPE_1 = 128,
  parameter int OUTPUT_SHAPE_2 = 128,
  parameter int LANES          = 16
) (
  input  logic                                                       clk_p,
  input  logic                                                       rst_n,
  input  logic                                                       start,
  input  logic [DATA_WIDTH*MATMUL_NUM*OUTPUT_SHAPE_1*OUTPUT_SHAPE_2-1:0] mul_in,
  output logic                                                       busy,
  output logic                                                       done,
  matmul_out_streamer_if.master                                      out_if
);

  localparam int HEAD_W = idx_w(MATMUL_NUM);
  localparam int ROW_W  = idx_w(OUTPUT_SHAPE_1);
  localparam int COL_W  = idx_w(OUTPUT_SHAPE_2);
  localparam int BUS_W  = DATA_WIDTH * MATMUL_NUM * OUTPUT_SHAPE_1 * OUTPUT_SHAPE_2;
  localparam int OFF_W  = idx_w(BUS_W);
  localparam int BEAT_W = DATA_WIDTH * LANES;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [BEAT_W-1:0] data_q, data_d;
  logic [HEAD_W-1:0] head_q, head_d, nxt_head;
  logic [ROW_W-1:0]  row_q, row_d, nxt_row;
  logic [COL_W-1:0]  col_q, col_d, nxt_col;
  logic              last_row_q, last_row_d, last_q, last_d;
  logic              nxt_last_row, nxt_last;
  logic              cnt_clear, cnt_en, load_beat, handshake;
  logic [31:0]       elem_idx;
  logic [OFF_W-1:0]  bit_off;
  logic [BEAT_W-1:0] beat_slice;

  matmul_beat_counter #(
    .MATMUL_NUM    (MATMUL_NUM),
    .OUTPUT_SHAPE_1(OUTPUT_SHAPE_1),
    .OUTPUT_SHAPE_2(OUTPUT_SHAPE_2),
    .LANES         (LANES),
    .HEAD_W        (HEAD_W),
    .ROW_W         (ROW_W),
    .COL_W         (COL_W)
  ) u_counter (
    .clk_p       (clk_p),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .en          (cnt_en),
    .nxt_head    (nxt_head),
    .nxt_row     (nxt_row),
    .nxt_col     (nxt_col),
    .nxt_last_row(nxt_last_row),
    .nxt_last    (nxt_last)
  );

  // A row's LANES elements starting at a LANES-aligned column are contiguous on the bus.
  always_comb begin
    elem_idx   = (32'(nxt_head) * OUTPUT_SHAPE_1 + 32'(nxt_row)) * OUTPUT_SHAPE_2 +
                 32'(nxt_col);
    bit_off    = OFF_W'(elem_idx * DATA_WIDTH);
    beat_slice = mul_in[bit_off +: BEAT_W];
  end

  assign handshake = valid_q & out_if.out_ready;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    load_beat  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_clear = 1'b1;
        load_beat = 1'b1;
        valid_d   = 1'b1;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          cnt_en = 1'b1;
          if (last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d     = load_beat ? beat_slice   : data_q;
    head_d     = load_beat ? nxt_head     : head_q;
    row_d      = load_beat ? nxt_row      : row_q;
    col_d      = load_beat ? nxt_col      : col_q;
    last_row_d = load_beat ? nxt_last_row : last_row_q;
    last_d     = load_beat ? nxt_last     : last_q;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      head_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      last_row_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      head_q     <= head_d;
      row_q      <= row_d;
      col_q      <= col_d;
      last_row_q <= last_row_d;
      last_q     <= last_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign out_if.out_valid    = valid_q;
  assign out_if.out_data     = data_q;
  assign out_if.out_head     = head_q;
  assign out_if.out_row      = row_q;
  assign out_if.out_col      = col_q;
  assign out_if.out_last_row = last_row_q;
  assign out_if.out_last     = last_q;

endmodule

// File: tb/tb_matmul_out_streamer.sv
// Bench for matmul_out_streamer on a 2x2x4 / 2-lane configuration, checked
// against a beat list built directly from the element addressing rule.
module tb_matmul_out_streamer;
  import matmul_pkg::*;

  localparam int DW = 8;
  localparam int MN = 2;
  localparam int S1 = 2;
  localparam int S2 = 4;
  localparam int LN = 2;
  localparam int NE = MN * S1 * S2;
  localparam int NB = beat_count(MN, S1, S2, LN);
  localparam int HW = idx_w(MN);
  localparam int RW = idx_w(S1);
  localparam int CW = idx_w(S2);

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DW*NE-1:0]  mul_in;
  logic              busy;
  logic              done;

  matmul_out_streamer_if #(
    .DATA_WIDTH(DW), .LANES(LN), .HEAD_W(HW), .ROW_W(RW), .COL_W(CW)
  ) sif ();

  matmul_out_streamer #(
    .DATA_WIDTH(DW), .MATMUL_NUM(MN), .OUTPUT_SHAPE_1(S1), .OUTPUT_SHAPE_2(S2), .LANES(LN)
  ) dut (
    .clk_p (clk_p),
    .rst_n (rst_n),
    .start (start),
    .mul_in(mul_in),
    .busy  (busy),
    .done  (done),
    .out_if(sif)
  );

  always #5 clk_p = ~clk_p;

  logic [7:0]       elem      [NE];
  logic [DW*LN-1:0] exp_data  [NB];
  int               exp_head  [NB];
  int               exp_row   [NB];
  int               exp_col   [NB];
  bit               exp_lrow  [NB];
  bit               exp_last  [NB];
  int               total = 0;
  int               bad   = 0;

  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Expected beats straight from the (m,r,c) addressing and traversal order.
  function automatic void build_model();
    int b = 0;
    for (int i = 0; i < NE; i++) mul_in[i*DW +: DW] = elem[i];
    for (int h = 0; h < MN; h++)
      for (int r = 0; r < S1; r++)
        for (int c = 0; c < S2; c += LN) begin
          for (int k = 0; k < LN; k++)
            exp_data[b][k*DW +: DW] = elem[(h*S1 + r)*S2 + c + k];
          exp_head[b] = h;
          exp_row[b]  = r;
          exp_col[b]  = c;
          exp_lrow[b] = (c + LN == S2);
          exp_last[b] = (b == NB - 1);
          b++;
        end
  endfunction

  function automatic void fill_linear(input int base);
    for (int i = 0; i < NE; i++) elem[i] = 8'(base + i);
    build_model();
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < NE; i++) elem[i] = 8'($urandom_range(255));
    build_model();
  endfunction

  // Issues start at the current negedge and follows the transfer to its done pulse.
  task automatic apply_stimulus(input int ready_pct, input int stall_beat, input int stall_len,
                                input int spur_beat, input bit rand_spur);
    int beat = 0;
    int cyc = 1;
    int stalls = 0;
    int stalled = 0;
    bit fin = 0;
    bit spur_done = 0;
    bit rdy;
    start = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
    while (!fin && cyc < 200) begin
      if (done) begin
        check_output("done_cycle", 64'(cyc), 64'(2 + NB + stalls));
        check_output("beat_total", 64'(beat), 64'(NB));
        check_output("busy_at_done", 64'(busy), 64'(0));
        check_output("valid_at_done", 64'(sif.out_valid), 64'(0));
        start = 1'b0;
        fin = 1;
      end else begin
        check_output($sformatf("busy_c%0d", cyc), 64'(busy), 64'(1));
        check_output($sformatf("valid_c%0d", cyc), 64'(sif.out_valid), 64'(cyc >= 2));
        if (sif.out_valid) begin
          check_output("beat_in_range", 64'(beat < NB), 64'(1));
          if (beat < NB) begin
            check_output($sformatf("data_b%0d", beat), 64'(sif.out_data), 64'(exp_data[beat]));
            check_output($sformatf("head_b%0d", beat), 64'(sif.out_head), 64'(exp_head[beat]));
            check_output($sformatf("row_b%0d", beat), 64'(sif.out_row), 64'(exp_row[beat]));
            check_output($sformatf("col_b%0d", beat), 64'(sif.out_col), 64'(exp_col[beat]));
            check_output($sformatf("lrow_b%0d", beat), 64'(sif.out_last_row),
                         64'(exp_lrow[beat]));
            check_output($sformatf("last_b%0d", beat), 64'(sif.out_last), 64'(exp_last[beat]));
          end
        end
        rdy = ($urandom_range(99) < ready_pct);
        if (sif.out_valid && beat == stall_beat && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end
        start = 1'b0;
        if (sif.out_valid && ((beat == spur_beat && !spur_done) ||
                              (rand_spur && $urandom_range(3) == 0))) begin
          start = 1'b1;
          spur_done = 1;
        end
        sif.out_ready = rdy;
        if (sif.out_valid && !rdy) stalls++;
        if (sif.out_valid && rdy) beat++;
        @(negedge clk_p);
        cyc++;
      end
    end
    if (!fin) check_output("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk_p);
    check_output({tag, "_done_once"}, 64'(done), 64'(0));
    check_output({tag, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 64'(busy), 64'(0));
    check_output({tag, "_done"}, 64'(done), 64'(0));
    check_output({tag, "_valid"}, 64'(sif.out_valid), 64'(0));
    check_output({tag, "_last"}, 64'(sif.out_last), 64'(0));
    check_output({tag, "_lrow"}, 64'(sif.out_last_row), 64'(0));
    check_output({tag, "_data"}, 64'(sif.out_data), 64'(0));
    check_output({tag, "_head"}, 64'(sif.out_head), 64'(0));
    check_output({tag, "_row"}, 64'(sif.out_row), 64'(0));
    check_output({tag, "_col"}, 64'(sif.out_col), 64'(0));
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    sif.out_ready = 1'b0;
    fill_linear(0);
    repeat (2) @(negedge clk_p);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_p);

    $display("[TB] ready tied high");
    apply_stimulus(100, -1, 0, -1, 0);
    check_idle_after("s1");

    $display("[TB] backpressure at beat 3");
    apply_stimulus(100, 3, 3, -1, 0);
    check_idle_after("s2");

    $display("[TB] spurious start at beat 4");
    apply_stimulus(100, -1, 0, 4, 0);
    check_idle_after("s3");

    $display("[TB] back-to-back transfers");
    apply_stimulus(100, -1, 0, -1, 0);
    apply_stimulus(100, -1, 0, -1, 0);
    check_idle_after("s4");

    $display("[TB] reset mid-transfer");
    start = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
    k = 0;
    while (!(sif.out_valid && sif.out_data == exp_data[5]) && k < 50) begin
      @(negedge clk_p);
      k++;
    end
    check_output("reach_beat5", 64'(k < 50), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_p);
    check_output("midrst_no_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk_p);
    apply_stimulus(100, -1, 0, -1, 0);
    check_idle_after("s5");

    $display("[TB] signed pass-through");
    fill_linear(8'h80);
    apply_stimulus(100, -1, 0, -1, 0);
    check_idle_after("s6");

    $display("[TB] randomized data and ready");
    for (int n = 0; n < 6; n++) begin
      fill_random();
      apply_stimulus(60, -1, 0, -1, 1);
      check_idle_after($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
